// File: rtl/crypto_wallet2_nios_fast_po_command_value_if.sv
// Bus bundle for the command-value output port: the Avalon-MM slave side
// facing the Nios data bus plus the valid/ready stream toward the consumer core.
// The "master" view is the environment (Nios + consumer); "slave" is the port block.
interface crypto_wallet2_nios_fast_po_command_value_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;
    logic             out_valid;
    logic             out_ready;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_port, out_valid, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_port, out_valid, irq
    );
endinterface

// File: rtl/crypto_wallet2_nios_fast_po_command_value.sv
// Command-value output PIO. The Nios writes command bytes to DATA; they are
// queued in a small FIFO and presented to a consumer over valid/ready.
// Register map: 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved.
// Optional feature macro: PO_IRQ_EN enables the drain interrupt and the
// irq_en bit of CONTROL. Without it irq is tied low and irq_en reads 0.
module crypto_wallet2_nios_fast_po_command_value #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic clk,
    input  logic reset,
    crypto_wallet2_nios_fast_po_command_value_if.slave bus
);

    localparam int CW = AW + 1;

    // Storage and FIFO bookkeeping
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] out_port_reg, out_port_next;
    logic             out_valid_reg;
    logic [WIDTH-1:0] last_push_reg;
    logic             overflow_reg;
    logic [31:0]      readdata_reg, readdata_next;

    // Bus decode
    logic             wr;
    logic             wr_data, wr_status, wr_ctrl;
    logic             empty, full;
    logic             pop, flush, push_ok, push_drop;
    logic [WIDTH-1:0] push_value;
    logic [AW-1:0]    rd_ptr_plus1;
    logic [DEPTH-1:0] slot_we;
    logic [7:0]       count_byte;
    logic             irq_en_bit;
    logic             unused_bits;

    assign wr         = bus.chipselect & ~bus.write_n;
    assign wr_data    = wr & (bus.address == 2'd0);
    assign wr_status  = wr & (bus.address == 2'd1);
    assign wr_ctrl    = wr & (bus.address == 2'd2);
    assign push_value = bus.writedata[WIDTH-1:0];

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

    // A transfer completes whenever the consumer takes the presented head,
    // even in the cycle a flush wipes the queue.
    assign pop   = out_valid_reg & bus.out_ready;
    assign flush = wr_ctrl & bus.writedata[0];

    // A full FIFO can still accept when the head leaves in the same cycle.
    assign push_ok   = wr_data & (~full | pop);
    assign push_drop = wr_data & ~push_ok;

    assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);
    assign count_byte   = 8'(count_reg);

    // Only part of writedata is meaningful; fold the rest so it is consumed.
    assign unused_bits = ^bus.writedata;

    // Per-slot write enables for the storage array
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push_ok & (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage write port; no reset needed since entries are only read once valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) begin
                mem[i] <= push_value;
            end
        end
    end

    // Next-state for pointers, occupancy and the presented head value
    always_comb begin
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;
        out_port_next = out_port_reg;
        if (flush) begin
            // Flush wins over a same-cycle pop; out_port keeps its last value.
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_plus1;
            end
            case ({push_ok, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
            // The head register always mirrors the oldest entry; when the FIFO
            // drains it simply keeps the value that was last popped.
            if (pop) begin
                if (count_reg > CW'(1)) begin
                    out_port_next = mem[rd_ptr_plus1];
                end else if (push_ok) begin
                    out_port_next = push_value;
                end
            end else if (empty && push_ok) begin
                out_port_next = push_value;
            end
        end
    end

    // FIFO state, stream outputs, DATA readback and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            out_port_reg  <= '0;
            out_valid_reg <= 1'b0;
            last_push_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            wr_ptr_reg    <= wr_ptr_next;
            count_reg     <= count_next;
            out_port_reg  <= out_port_next;
            out_valid_reg <= (count_next != '0);
            if (push_ok) begin
                last_push_reg <= push_value;
            end
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end else if (wr_status && bus.writedata[2]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef PO_IRQ_EN
    logic irq_en_reg;
    logic irq_reg;

    // Drain interrupt: level, asserted one cycle after the FIFO runs empty
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_reg <= bus.writedata[1];
            end
            irq_reg <= irq_en_reg & empty & ~flush;
        end
    end

    assign irq_en_bit = irq_en_reg;
    assign bus.irq    = irq_reg;
`else
    assign irq_en_bit = 1'b0;
    assign bus.irq    = 1'b0;
`endif

    // Read mux from the current register state
    always_comb begin
        readdata_next = '0;
        case (bus.address)
            2'd0:    readdata_next = 32'(last_push_reg);
            2'd1:    readdata_next = {16'b0, count_byte, 5'b0, overflow_reg, full, empty};
            2'd2:    readdata_next = {30'b0, irq_en_bit, 1'b0};
            default: readdata_next = '0;
        endcase
    end

    // Registered readdata, updated every cycle with one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else begin
            readdata_reg <= readdata_next;
        end
    end

    assign bus.readdata  = readdata_reg;
    assign bus.out_port  = out_port_reg;
    assign bus.out_valid = out_valid_reg;

endmodule
